// File: rtl/pattern_sequencer_pkg.sv
// Shared constants and types for the pattern sequencer and its input stage.
//   BUF_AW/DW/SW/VAR_AW : buffer-half word address, BRAM data, sample and
//                         variable RAM address widths
//   V_*                 : variable RAM slot indices
//   seq_state_e         : sequencer FSM encoding
//   next_word_addr()    : port-B address of the word played after the current one
package pattern_sequencer_pkg;

  localparam int BUF_AW = 11;
  localparam int DW     = 32;
  localparam int SW     = 16;
  localparam int VAR_AW = 4;

  localparam logic [VAR_AW-1:0] V_WCOUNT = VAR_AW'(0);
  localparam logic [VAR_AW-1:0] V_DIV    = VAR_AW'(1);
  localparam logic [VAR_AW-1:0] V_CTRL   = VAR_AW'(2);

  // Largest legal word count (a full half); encoded as 0x800.
  localparam logic [BUF_AW:0] MAX_WORDS = 12'h800;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_VARS = 3'd1,
    ST_PREFETCH  = 3'd2,
    ST_RUN       = 3'd3,
    ST_WAIT_FULL = 3'd4
  } seq_state_e;

  // ab is the active_buffer value in force while the fetched word is played.
  // Past the last word of a half the fetch moves to word 0 of the half the
  // input stage is filling, so a gap-free swap finds its first word ready.
  function automatic logic [BUF_AW:0] next_word_addr(
    input logic            ab,
    input logic [BUF_AW:0] nxt_idx,
    input logic [BUF_AW:0] wcount
  );
    if (nxt_idx == wcount) next_word_addr = {ab, {BUF_AW{1'b0}}};
    else                   next_word_addr = {~ab, nxt_idx[BUF_AW-1:0]};
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Bus bundle between the pattern sequencer and its surroundings
// (control strobes, BRAM/variable RAM port B, sample output, status).
//   master : the sequencer
//   slave  : control logic, RAMs and sample consumer
interface pattern_sequencer_if;
  import pattern_sequencer_pkg::*;

  logic              start;
  logic              stop;
  logic              load_complete;
  logic              active_buffer;
  logic [BUF_AW:0]   daddr_b;
  logic [DW-1:0]     dout_b;
  logic [VAR_AW-1:0] vaddr_b;
  logic [DW-1:0]     vout_b;
  logic [SW-1:0]     pattern_out;
  logic              pattern_valid;
  logic              buffer_done;
  logic              busy;
  logic              underrun;
  logic              overrun;
  logic              cfg_err;

  modport master (
    input  start, stop, load_complete, dout_b, vout_b,
    output active_buffer, daddr_b, vaddr_b, pattern_out, pattern_valid,
           buffer_done, busy, underrun, overrun, cfg_err
  );

  modport slave (
    output start, stop, load_complete, dout_b, vout_b,
    input  active_buffer, daddr_b, vaddr_b, pattern_out, pattern_valid,
           buffer_done, busy, underrun, overrun, cfg_err
  );

endinterface

// File: rtl/pattern_sequencer_sample_timer.sv
// Sample hold timer: 16-bit down-counter reloaded with div at the start of
// every sample; expire_o is high on the last clock of the hold.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : start a new hold period
//   div_i      : hold length minus one
//   expire_o   : current sample is in its final clock
module pattern_sequencer_sample_timer
  import pattern_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [SW-1:0] div_i,
  output logic          expire_o
);

  logic [SW-1:0] count_q, count_d;

  // Parks at zero instead of wrapping when no reload follows.
  always_comb begin
    count_d = count_q;
    if (load_i)              count_d = div_i;
    else if (count_q != '0)  count_d = count_q - SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expire_o = (count_q == '0);

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: plays the loaded half of the double-buffered data BRAM
// as 16-bit samples (low half of each word first) at div+1 clocks per sample,
// then swaps halves without a gap when the input stage has the other half full.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of pattern_sequencer_if (strobes, RAM port B,
//                sample output, sticky status flags)
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | waiting for start with a full half available
// LOAD_VARS | reading word count, divider and loop flag from variable RAM
// PREFETCH  | first word address out, waiting for BRAM read data
// RUN       | playing samples; next word fetched one sample ahead
// WAIT_FULL | looping but the next half is not full yet (underrun)
module pattern_sequencer
  import pattern_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  pattern_sequencer_if.master  bus
);

  seq_state_e        state_q;
  logic [1:0]        step_q;
  logic              ab_q;
  logic              pending_q;
  logic              stop_seen_q;
  logic [BUF_AW:0]   wcount_q;
  logic [SW-1:0]     div_q;
  logic              loop_q;
  logic [BUF_AW:0]   daddr_q;
  logic [VAR_AW-1:0] vaddr_q;
  logic [BUF_AW-1:0] widx_q;
  logic              phase_hi_q;
  logic [SW-1:0]     pat_q;
  logic [SW-1:0]     hi_q;
  logic              valid_q;
  logic              done_q;
  logic              underrun_q;
  logic              overrun_q;
  logic              cfg_err_q;

  logic              tmr_load;
  logic              tmr_expire;
  logic              swap_ok;
  logic              stop_now;
  logic              last_word;
  logic              bad_wcount;
  logic [BUF_AW:0]   widx_ext;
  logic [BUF_AW-1:0] widx_d;
  logic              unused_vout;

  assign widx_ext   = {1'b0, widx_q};
  assign widx_d     = widx_q + BUF_AW'(1);
  assign last_word  = (widx_ext + (BUF_AW+1)'(1)) == wcount_q;
  assign swap_ok    = pending_q | bus.load_complete;
  assign stop_now   = stop_seen_q | bus.stop;
  assign bad_wcount = (bus.vout_b[BUF_AW:0] == '0) ||
                      (bus.vout_b[BUF_AW:0] > MAX_WORDS);
  assign unused_vout = ^bus.vout_b[DW-1:SW];

  // A new sample starts on the clock after the first word arrives and after
  // every expiry while running.
  assign tmr_load = ((state_q == ST_PREFETCH) && step_q[0]) ||
                    ((state_q == ST_RUN) && tmr_expire);

  pattern_sequencer_sample_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tmr_load),
    .div_i    (div_q),
    .expire_o (tmr_expire)
  );

  // Later assignments in this block override earlier ones, so the generic
  // pending/stop bookkeeping at the top is superseded by consuming events.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      ab_q        <= 1'b1;
      pending_q   <= 1'b0;
      stop_seen_q <= 1'b0;
      wcount_q    <= '0;
      div_q       <= '0;
      loop_q      <= 1'b0;
      daddr_q     <= '0;
      vaddr_q     <= '0;
      widx_q      <= '0;
      phase_hi_q  <= 1'b0;
      pat_q       <= '0;
      hi_q        <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load_complete && pending_q) overrun_q <= 1'b1;
      if (bus.load_complete)              pending_q <= 1'b1;
      if ((state_q != ST_IDLE) && bus.stop) stop_seen_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (bus.start && swap_ok) begin
            state_q     <= ST_LOAD_VARS;
            step_q      <= '0;
            vaddr_q     <= V_WCOUNT;
            ab_q        <= ~ab_q;
            pending_q   <= 1'b0;
            stop_seen_q <= 1'b0;
          end
        end

        ST_LOAD_VARS: begin
          step_q <= step_q + 2'd1;
          case (step_q)
            2'd0: vaddr_q <= V_DIV;
            2'd1: begin
              vaddr_q  <= V_CTRL;
              wcount_q <= bus.vout_b[BUF_AW:0];
              if (bad_wcount) begin
                cfg_err_q   <= 1'b1;
                state_q     <= ST_IDLE;
                stop_seen_q <= 1'b0;
              end
            end
            2'd2: div_q <= bus.vout_b[SW-1:0];
            default: begin
              loop_q  <= bus.vout_b[0];
              daddr_q <= {~ab_q, {BUF_AW{1'b0}}};
              step_q  <= '0;
              state_q <= ST_PREFETCH;
            end
          endcase
        end

        ST_PREFETCH: begin
          if (!step_q[0]) begin
            step_q <= 2'd1;
          end else begin
            pat_q      <= bus.dout_b[SW-1:0];
            hi_q       <= bus.dout_b[DW-1:SW];
            valid_q    <= 1'b1;
            widx_q     <= '0;
            phase_hi_q <= 1'b0;
            daddr_q    <= next_word_addr(ab_q, (BUF_AW+1)'(1), wcount_q);
            state_q    <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (tmr_expire) begin
            if (!phase_hi_q) begin
              pat_q      <= hi_q;
              phase_hi_q <= 1'b1;
            end else if (!last_word) begin
              // The fetch issued when this word's low sample began has had at
              // least one full clock to return, even at div=0.
              pat_q      <= bus.dout_b[SW-1:0];
              hi_q       <= bus.dout_b[DW-1:SW];
              widx_q     <= widx_d;
              phase_hi_q <= 1'b0;
              daddr_q    <= next_word_addr(ab_q, widx_ext + (BUF_AW+1)'(2), wcount_q);
            end else begin
              done_q      <= 1'b1;
              stop_seen_q <= 1'b0;
              if (!loop_q || stop_now) begin
                pat_q   <= '0;
                valid_q <= 1'b0;
                state_q <= ST_IDLE;
              end else if (swap_ok) begin
                ab_q       <= ~ab_q;
                pending_q  <= 1'b0;
                pat_q      <= bus.dout_b[SW-1:0];
                hi_q       <= bus.dout_b[DW-1:SW];
                widx_q     <= '0;
                phase_hi_q <= 1'b0;
                daddr_q    <= next_word_addr(~ab_q, (BUF_AW+1)'(1), wcount_q);
              end else begin
                underrun_q <= 1'b1;
                pat_q      <= '0;
                valid_q    <= 1'b0;
                state_q    <= ST_WAIT_FULL;
              end
            end
          end
        end

        ST_WAIT_FULL: begin
          if (bus.stop) begin
            state_q     <= ST_IDLE;
            stop_seen_q <= 1'b0;
          end else if (swap_ok) begin
            ab_q      <= ~ab_q;
            pending_q <= 1'b0;
            daddr_q   <= {ab_q, {BUF_AW{1'b0}}};
            step_q    <= '0;
            state_q   <= ST_PREFETCH;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.active_buffer = ab_q;
  assign bus.daddr_b       = daddr_q;
  assign bus.vaddr_b       = vaddr_q;
  assign bus.pattern_out   = pat_q;
  assign bus.pattern_valid = valid_q;
  assign bus.buffer_done   = done_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.underrun      = underrun_q;
  assign bus.overrun       = overrun_q;
  assign bus.cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;
  import pattern_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  pattern_sequencer_if bus();

  pattern_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] dmem [4096];
  logic [31:0] vmem [16];

  // Port-B RAM models with one-cycle registered read latency.
  always @(posedge clk) begin
    bus.dout_b <= dmem[bus.daddr_b];
    bus.vout_b <= vmem[bus.vaddr_b];
  end

  int vectors = 0;
  int errors  = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_s;

  // Scoreboard: every live sample must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.pattern_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sample_unexpected got %h required none", bus.pattern_out);
      end else begin
        exp_s = exp_q.pop_front();
        if (bus.pattern_out !== exp_s) begin
          errors++;
          $display("FAIL sample got %h required %h", bus.pattern_out, exp_s);
        end
      end
    end
  end

  int w_first, w_rise, w_last, w_nvalid, w_ndone, w_abtog;
  logic w_ab1, w_p_uf, w_p_v, w_p_busy;

  task automatic load_half(input int half, input int base, input int nwords);
    for (int i = 0; i < nwords; i++)
      dmem[half*2048 + i] = {16'(base + 2*i + 1), 16'(base + 2*i)};
  endtask

  task automatic push_samples(input int base, input int nsamples, input int hold);
    for (int i = 0; i < nsamples; i++)
      for (int h = 0; h < hold; h++)
        exp_q.push_back(16'(base + i));
  endtask

  task automatic set_vars(input int wc, input int dv, input int lp);
    vmem[0] = 32'(wc);
    vmem[1] = 32'(dv);
    vmem[2] = 32'(lp);
  endtask

  task automatic trigger(input logic lc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.load_complete = lc;
  endtask

  // Observes budget clocks after a trigger; k=1 is the clock after the trigger
  // edge. Optional load_complete/stop pulses are driven at given clocks.
  task automatic watch(input int budget, input int lc_at, input int stop_at, input int probe_at);
    logic prev_v, prev_ab;
    w_first = -1; w_rise = -1; w_last = -1; w_nvalid = 0; w_ndone = 0; w_abtog = 0;
    prev_v = 1'b0; prev_ab = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        w_ab1 = bus.active_buffer;
        prev_ab = bus.active_buffer;
      end else if (bus.active_buffer !== prev_ab) begin
        w_abtog++;
        prev_ab = bus.active_buffer;
      end
      if (bus.pattern_valid) begin
        if (w_first < 0) w_first = k;
        if (!prev_v) w_rise = k;
        w_last = k;
        w_nvalid++;
      end
      prev_v = bus.pattern_valid;
      if (bus.buffer_done) w_ndone++;
      if (k == probe_at) begin
        w_p_uf = bus.underrun;
        w_p_v = bus.pattern_valid;
        w_p_busy = bus.busy;
      end
      bus.start = 1'b0;
      bus.load_complete = (k == lc_at);
      bus.stop = (k == stop_at);
    end
    bus.load_complete = 1'b0;
    bus.stop = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.active_buffer, bus.busy, bus.pattern_valid, bus.buffer_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 1000",
               {bus.active_buffer, bus.busy, bus.pattern_valid, bus.buffer_done});
    end
    vectors++;
    if ({bus.daddr_b, bus.vaddr_b, bus.pattern_out} !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got %h required 0", {bus.daddr_b, bus.vaddr_b, bus.pattern_out});
    end
    vectors++;
    if ({bus.underrun, bus.overrun, bus.cfg_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b required 000", {bus.underrun, bus.overrun, bus.cfg_err});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_buffer;
    set_vars(4, 0, 0);
    load_half(1, 1, 4);
    push_samples(1, 8, 1);
    trigger(1'b1);
    watch(20, 0, 0, 0);
    vectors++;
    if (w_ab1 !== 1'b0) begin errors++; $display("FAIL single_ab_cycle1 got %b required 0", w_ab1); end
    vectors++;
    if (w_first != 7) begin errors++; $display("FAIL single_first got %0d required 7", w_first); end
    vectors++;
    if (w_nvalid != 8 || w_last != 14) begin
      errors++; $display("FAIL single_valid got %0d/%0d required 8/14", w_nvalid, w_last);
    end
    vectors++;
    if (w_ndone != 1 || w_abtog != 0) begin
      errors++; $display("FAIL single_done_ab got %0d/%0d required 1/0", w_ndone, w_abtog);
    end
    vectors++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL single_end got busy=%b left=%0d required 0/0", bus.busy, exp_q.size());
    end
  endtask

  task automatic test_divider;
    set_vars(4, 2, 0);
    load_half(0, 1, 4);
    push_samples(1, 8, 3);
    trigger(1'b1);
    watch(36, 0, 0, 0);
    vectors++;
    if (w_first != 7 || w_nvalid != 24 || w_last != 30) begin
      errors++; $display("FAIL div_valid got %0d/%0d/%0d required 7/24/30", w_first, w_nvalid, w_last);
    end
    vectors++;
    if (w_ndone != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL div_end got %0d/%0d required 1/0", w_ndone, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    set_vars(4, 0, 1);
    load_half(1, 16'h0101, 4);
    load_half(0, 16'h0201, 4);
    push_samples(16'h0101, 8, 1);
    push_samples(16'h0201, 8, 1);
    trigger(1'b1);
    watch(28, 9, 18, 0);
    vectors++;
    if (w_first != 7 || w_nvalid != 16 || (w_last - w_first + 1) != 16) begin
      errors++; $display("FAIL swap_gapfree got %0d/%0d/%0d required 7/16/22", w_first, w_nvalid, w_last);
    end
    vectors++;
    if (w_ab1 !== 1'b0 || w_abtog != 1 || bus.active_buffer !== 1'b1) begin
      errors++; $display("FAIL swap_ab got %b/%0d required 0/1", w_ab1, w_abtog);
    end
    vectors++;
    if (w_ndone != 2 || exp_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL swap_end got %0d/%0d/%b required 2/0/0", w_ndone, exp_q.size(), bus.busy);
    end
  endtask

  task automatic test_underrun;
    set_vars(2, 0, 1);
    load_half(1, 16'h0301, 2);
    load_half(0, 16'h0401, 2);
    push_samples(16'h0301, 4, 1);
    push_samples(16'h0401, 4, 1);
    trigger(1'b1);
    watch(28, 15, 19, 12);
    vectors++;
    if ({w_p_uf, w_p_v, w_p_busy} !== 3'b101) begin
      errors++; $display("FAIL underrun_wait got %b required 101", {w_p_uf, w_p_v, w_p_busy});
    end
    vectors++;
    if (w_first != 7 || w_rise != 18 || w_nvalid != 8) begin
      errors++; $display("FAIL underrun_resume got %0d/%0d/%0d required 7/18/8", w_first, w_rise, w_nvalid);
    end
    vectors++;
    if (w_ndone != 2 || w_abtog != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL underrun_end got %0d/%0d/%0d required 2/1/0", w_ndone, w_abtog, exp_q.size());
    end
  endtask

  task automatic test_cfg_overrun;
    set_vars(0, 0, 0);
    trigger(1'b1);
    watch(12, 0, 0, 0);
    vectors++;
    if (w_nvalid != 0 || bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL cfg_err got %0d/%b/%b required 0/1/0", w_nvalid, bus.cfg_err, bus.busy);
    end
    @(negedge clk); bus.load_complete = 1'b1;
    @(negedge clk); bus.load_complete = 1'b0;
    vectors++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_first got %b required 0", bus.overrun); end
    @(negedge clk); bus.load_complete = 1'b1;
    @(negedge clk); bus.load_complete = 1'b0;
    vectors++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_second got %b required 1", bus.overrun); end
  endtask

  task automatic test_reset_midrun;
    set_vars(4, 0, 0);
    load_half(0, 16'h0010, 4);
    push_samples(16'h0010, 3, 1);
    trigger(1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.active_buffer, bus.busy, bus.pattern_valid, bus.buffer_done,
         bus.underrun, bus.overrun, bus.cfg_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL midrun_reset_ctrl got %b required 1000000",
               {bus.active_buffer, bus.busy, bus.pattern_valid, bus.buffer_done,
                bus.underrun, bus.overrun, bus.cfg_err});
    end
    vectors++;
    if ({bus.daddr_b, bus.vaddr_b, bus.pattern_out} !== 32'h0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrun_reset_bus got %h left=%0d required 0/0",
               {bus.daddr_b, bus.vaddr_b, bus.pattern_out}, exp_q.size());
    end
    reset = 1'b0;
    load_half(1, 16'h0010, 4);
    push_samples(16'h0010, 8, 1);
    trigger(1'b1);
    watch(20, 0, 0, 0);
    vectors++;
    if (w_first != 7 || w_nvalid != 8 || w_ndone != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrun_replay got %0d/%0d/%0d/%0d required 7/8/1/0",
               w_first, w_nvalid, w_ndone, exp_q.size());
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.load_complete = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4096; i++) dmem[i] = '0;
    for (int i = 0; i < 16; i++) vmem[i] = '0;
    test_reset();
    test_single_buffer();
    test_divider();
    test_back_to_back();
    test_underrun();
    test_cfg_overrun();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
